timer_bank: RTL and testbench

- Parametrised 8051-style timer/counter block, replacing the single-timer design.
- Holds TMOD plus TLx/THx for NUM_TIMERS timers (1 or 2).
- Adds a machine-cycle prescaler, GATE qualification by the INTx pins, external-pin counter mode, mode-3 split, and sticky TFx flags cleared by interrupt acknowledge.
- Sits beside the SFR decoder. TRx bits come from the TCON register; TFx flags go back to TCON and the interrupt controller.

---
 rtl/timer_bank.sv | 184 ++++++++++++++++++
 tb/tb_timer_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: 8051-style timer/counter bank (TMOD, TLx/THx, TFx) for 1 or 2 timers.
// Machine-cycle prescaler, GATE qualification by INTx, modes 0-3, sticky TF flags.
// Optional macro TIMER_EXT_COUNT_EN: when defined, C/T=1 counts falling edges on t_pin;
// when undefined, C/T is ignored and every timer counts prescaler ticks.

`ifndef SFR_TMOD
`define SFR_TMOD 8'h89
`endif
`ifndef SFR_TL0
`define SFR_TL0 8'h8A
`endif
`ifndef SFR_TL1
`define SFR_TL1 8'h8B
`endif
`ifndef SFR_TH0
`define SFR_TH0 8'h8C
`endif
`ifndef SFR_TH1
`define SFR_TH1 8'h8D
`endif

module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int PRESCALE   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              wr_addr,
  input  logic [7:0]              data_in,
  input  logic                    wr,
  input  logic                    wr_bit,
  input  logic [NUM_TIMERS-1:0]   tr,
  input  logic [NUM_TIMERS-1:0]   int_n,
  input  logic [NUM_TIMERS-1:0]   t_pin,
  input  logic [NUM_TIMERS-1:0]   int_ack,
  output logic [7:0]              tmod,
  output logic [8*NUM_TIMERS-1:0] tl,
  output logic [8*NUM_TIMERS-1:0] th,
  output logic [NUM_TIMERS-1:0]   tf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]         r_presc;
  logic [7:0]            r_tmod;
  logic [7:0]            r_tl [NUM_TIMERS];
  logic [7:0]            r_th [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_tf;
  logic [NUM_TIMERS-1:0] r_int_s1, r_int_s2;

  logic                  w_tick, w_wr_byte, w_wr_tmod, w_th0_evt, w_th0_ovf, w_t0_mode3;
  logic [1:0]            w_tr2;
  logic [1:0]            w_mode [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] w_run, w_src, w_evt, w_wr_tl, w_wr_th, w_wr_tim, w_ovf, w_tf_set;
  logic [7:0]            w_tl_nx [NUM_TIMERS];
  logic [7:0]            w_th_nx [NUM_TIMERS];

  assign w_tick     = (r_presc == PW'(PRESCALE - 1));
  assign w_wr_byte  = wr & ~wr_bit;
  assign w_wr_tmod  = w_wr_byte & (wr_addr == `SFR_TMOD);
  assign w_tr2      = 2'(tr);
  // In mode 3, TH0 borrows TR1 and runs from the tick only.
  assign w_th0_evt  = (NUM_TIMERS == 2) & w_tr2[1] & w_tick;
  assign w_t0_mode3 = (w_mode[0] == 2'd3);
  assign tmod       = r_tmod;
  assign tf         = r_tf;

`ifdef TIMER_EXT_COUNT_EN
  logic [NUM_TIMERS-1:0] r_t_s1, r_t_s2, r_t_s3;
  logic [NUM_TIMERS-1:0] w_fall;
  assign w_fall = r_t_s3 & ~r_t_s2;

  // t_pin synchroniser plus edge register, idle-high after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_t_s1 <= '1;
      r_t_s2 <= '1;
      r_t_s3 <= '1;
    end else begin
      r_t_s1 <= t_pin;
      r_t_s2 <= r_t_s1;
      r_t_s3 <= r_t_s2;
    end
  end
`else
  logic w_unused_tpin;
  assign w_unused_tpin = ^t_pin;
`endif

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_tim
    localparam logic [7:0] A_TL = (gi == 0) ? `SFR_TL0 : `SFR_TL1;
    localparam logic [7:0] A_TH = (gi == 0) ? `SFR_TH0 : `SFR_TH1;
    assign w_mode[gi]   = r_tmod[4*gi +: 2];
    assign w_run[gi]    = tr[gi] & (~r_tmod[4*gi+3] | r_int_s2[gi]);
`ifdef TIMER_EXT_COUNT_EN
    assign w_src[gi]    = r_tmod[4*gi+2] ? w_fall[gi] : w_tick;
`else
    assign w_src[gi]    = w_tick;
`endif
    assign w_evt[gi]    = w_run[gi] & w_src[gi];
    assign w_wr_tl[gi]  = w_wr_byte & (wr_addr == A_TL);
    assign w_wr_th[gi]  = w_wr_byte & (wr_addr == A_TH);
    assign w_wr_tim[gi] = w_wr_tl[gi] | w_wr_th[gi];
    assign tl[8*gi +: 8] = r_tl[gi];
    assign th[8*gi +: 8] = r_th[gi];
  end

  // Next counter values and overflow; a byte write to the timer overrides counting
  always_comb begin
    w_th0_ovf = 1'b0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_tl_nx[i] = r_tl[i];
      w_th_nx[i] = r_th[i];
      w_ovf[i]   = 1'b0;
      if (w_evt[i]) begin
        case (w_mode[i])
          2'd0: begin
            {w_th_nx[i], w_tl_nx[i][4:0]} = {r_th[i], r_tl[i][4:0]} + 13'd1;
            w_ovf[i] = &{r_th[i], r_tl[i][4:0]};
          end
          2'd1: begin
            {w_th_nx[i], w_tl_nx[i]} = {r_th[i], r_tl[i]} + 16'd1;
            w_ovf[i] = &{r_th[i], r_tl[i]};
          end
          2'd2: begin
            if (&r_tl[i]) begin
              w_tl_nx[i] = r_th[i];
              w_ovf[i]   = 1'b1;
            end else begin
              w_tl_nx[i] = r_tl[i] + 8'd1;
            end
          end
          default: begin
            if (i == 0) begin
              w_tl_nx[i] = r_tl[i] + 8'd1;
              w_ovf[i]   = &r_tl[i];
            end
          end
        endcase
      end
      if (i == 0 && w_t0_mode3 && w_th0_evt) begin
        w_th_nx[i] = r_th[i] + 8'd1;
        w_th0_ovf  = &r_th[i];
      end
      if (w_wr_tim[i]) begin
        w_tl_nx[i] = w_wr_tl[i] ? data_in : r_tl[i];
        w_th_nx[i] = w_wr_th[i] ? data_in : r_th[i];
      end
    end
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_tf_set[i] = w_ovf[i] & ~w_wr_tim[i];
    end
    // TH0 owns tf[1] while timer 0 is split
    if (NUM_TIMERS == 2 && w_t0_mode3) begin
      w_tf_set[NUM_TIMERS-1] = w_th0_ovf & ~w_wr_tim[0];
    end
  end

  // Prescaler, INTx synchroniser, TMOD, counters and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc  <= '0;
      r_tmod   <= 8'h00;
      r_tf     <= '0;
      r_int_s1 <= '1;
      r_int_s2 <= '1;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        r_tl[i] <= 8'h00;
        r_th[i] <= 8'h00;
      end
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      r_int_s1 <= int_n;
      r_int_s2 <= r_int_s1;
      if (w_wr_tmod) r_tmod <= data_in;
      r_tf <= (r_tf & ~int_ack) | w_tf_set;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        r_tl[i] <= w_tl_nx[i];
        r_th[i] <= w_th_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank with PRESCALE=1 (dut a) and PRESCALE=12 (dut b).
module tb_timer_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  wr_addr, data_in;
  logic        wr, wr_bit;
  logic [1:0]  tr, int_n, t_pin, int_ack;
  logic [7:0]  tmod_a, tmod_b;
  logic [15:0] tl_a, th_a, tl_b, th_b;
  logic [1:0]  tf_a, tf_b;
  int checks = 0;
  int errors = 0;

  timer_bank #(.NUM_TIMERS(2), .PRESCALE(1)) u_a (
    .clock(clock), .reset(reset), .wr_addr(wr_addr), .data_in(data_in), .wr(wr),
    .wr_bit(wr_bit), .tr(tr), .int_n(int_n), .t_pin(t_pin), .int_ack(int_ack),
    .tmod(tmod_a), .tl(tl_a), .th(th_a), .tf(tf_a));

  timer_bank #(.NUM_TIMERS(2), .PRESCALE(12)) u_b (
    .clock(clock), .reset(reset), .wr_addr(wr_addr), .data_in(data_in), .wr(wr),
    .wr_bit(wr_bit), .tr(tr), .int_n(int_n), .t_pin(t_pin), .int_ack(int_ack),
    .tmod(tmod_b), .tl(tl_b), .th(th_b), .tf(tf_b));

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    wr_addr = a; data_in = d; wr = 1'b1;
    cyc(1);
    wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tr = 2'b00; int_ack = 2'b00; wr = 1'b0; wr_bit = 1'b0;
    int_n = 2'b11; t_pin = 2'b11;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({tmod_a, tl_a, th_a, tf_a} !== 42'd0) begin errors++;
      $display("FAIL reset_a got %h exp 0", {tmod_a, tl_a, th_a, tf_a}); end
    checks++; if ({tmod_b, tl_b, th_b, tf_b} !== 42'd0) begin errors++;
      $display("FAIL reset_b got %h exp 0", {tmod_b, tl_b, th_b, tf_b}); end
    wr_bit = 1'b1; sfr_wr(8'h8A, 8'h55); wr_bit = 1'b0;
    checks++; if (tl_a !== 16'h0000) begin errors++;
      $display("FAIL wr_bit_ignored got %h exp 0000", tl_a); end
    sfr_wr(8'h89, 8'h21);
    checks++; if (tmod_a !== 8'h21 || tf_a !== 2'b00) begin errors++;
      $display("FAIL tmod_write got %h/%b exp 21/00", tmod_a, tf_a); end
  endtask

  task automatic test_mode1_overflow();
    do_reset();
    sfr_wr(8'h89, 8'h01); sfr_wr(8'h8C, 8'hFF); sfr_wr(8'h8A, 8'hFE);
    tr = 2'b01;
    cyc(1);
    checks++; if (th_a[7:0] !== 8'hFF || tl_a[7:0] !== 8'hFF || tf_a[0] !== 1'b0) begin errors++;
      $display("FAIL m1_step1 got %h%h tf %b exp FFFF tf 0", th_a[7:0], tl_a[7:0], tf_a[0]); end
    cyc(1);
    checks++; if (th_a[7:0] !== 8'h00 || tl_a[7:0] !== 8'h00 || tf_a[0] !== 1'b1) begin errors++;
      $display("FAIL m1_wrap got %h%h tf %b exp 0000 tf 1", th_a[7:0], tl_a[7:0], tf_a[0]); end
    tr = 2'b00;
    cyc(3);
    checks++; if (tf_a[0] !== 1'b1) begin errors++;
      $display("FAIL m1_sticky got %b exp 1", tf_a[0]); end
    int_ack = 2'b01; cyc(1); int_ack = 2'b00;
    checks++; if (tf_a[0] !== 1'b0) begin errors++;
      $display("FAIL m1_ack got %b exp 0", tf_a[0]); end
  endtask

  task automatic test_mode2_reload();
    do_reset();
    sfr_wr(8'h89, 8'h02); sfr_wr(8'h8C, 8'hF0); sfr_wr(8'h8A, 8'hFE);
    tr = 2'b01;
    cyc(1);
    checks++; if (tl_a[7:0] !== 8'hFF || tf_a[0] !== 1'b0) begin errors++;
      $display("FAIL m2_ff got %h tf %b exp FF tf 0", tl_a[7:0], tf_a[0]); end
    cyc(1);
    checks++; if (tl_a[7:0] !== 8'hF0 || tf_a[0] !== 1'b1) begin errors++;
      $display("FAIL m2_reload got %h tf %b exp F0 tf 1", tl_a[7:0], tf_a[0]); end
    cyc(1);
    tr = 2'b00;
    checks++; if (tl_a[7:0] !== 8'hF1 || th_a[7:0] !== 8'hF0) begin errors++;
      $display("FAIL m2_next got %h/%h exp F1/F0", tl_a[7:0], th_a[7:0]); end
  endtask

  task automatic test_gate();
    do_reset();
    int_n = 2'b10;
    sfr_wr(8'h89, 8'h09);
    cyc(2);
    tr = 2'b01;
    cyc(48);
    checks++; if (tl_b[7:0] !== 8'h00 || th_b[7:0] !== 8'h00) begin errors++;
      $display("FAIL gate_low got %h%h exp 0000", th_b[7:0], tl_b[7:0]); end
    int_n = 2'b11;
    cyc(48);
    int_n = 2'b10;
    cyc(4);
    tr = 2'b00;
    checks++; if (tl_b[7:0] !== 8'h04 || th_b[7:0] !== 8'h00) begin errors++;
      $display("FAIL gate_high got %h%h exp 0004", th_b[7:0], tl_b[7:0]); end
  endtask

`ifdef TIMER_EXT_COUNT_EN
  task automatic test_ext_count();
    do_reset();
    sfr_wr(8'h89, 8'h05);
    tr = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      t_pin = 2'b10;
      cyc(2);
      checks++; if (tl_a[7:0] !== 8'(k - 1)) begin errors++;
        $display("FAIL ext_early got %h exp %h", tl_a[7:0], 8'(k - 1)); end
      cyc(1);
      checks++; if (tl_a[7:0] !== 8'(k)) begin errors++;
        $display("FAIL ext_edge got %h exp %h", tl_a[7:0], 8'(k)); end
      t_pin = 2'b11;
      cyc(4);
      checks++; if (tl_a[7:0] !== 8'(k)) begin errors++;
        $display("FAIL ext_rise got %h exp %h", tl_a[7:0], 8'(k)); end
    end
    tr = 2'b00;
  endtask
`else
  task automatic test_ct_ignored();
    do_reset();
    sfr_wr(8'h89, 8'h05);
    tr = 2'b01;
    for (int k = 0; k < 5; k++) begin
      t_pin = {1'b1, k[0]};
      cyc(1);
    end
    tr = 2'b00; t_pin = 2'b11;
    cyc(4);
    checks++; if (tl_a[7:0] !== 8'h05 || th_a[7:0] !== 8'h00) begin errors++;
      $display("FAIL ct_ignored got %h%h exp 0005", th_a[7:0], tl_a[7:0]); end
  endtask
`endif

  task automatic test_mode3();
    do_reset();
    sfr_wr(8'h89, 8'h33); sfr_wr(8'h8A, 8'hFF); sfr_wr(8'h8C, 8'hFF);
    sfr_wr(8'h8B, 8'hAB); sfr_wr(8'h8D, 8'hCD);
    tr = 2'b11; cyc(1); tr = 2'b00;
    checks++; if (tl_a !== 16'hAB00 || th_a !== 16'hCD00) begin errors++;
      $display("FAIL m3_regs got tl %h th %h exp AB00 CD00", tl_a, th_a); end
    checks++; if (tf_a !== 2'b11) begin errors++;
      $display("FAIL m3_flags got %b exp 11", tf_a); end
    do_reset();
    sfr_wr(8'h89, 8'h13); sfr_wr(8'h8B, 8'hFF); sfr_wr(8'h8D, 8'hFF);
    tr = 2'b11; cyc(1); tr = 2'b00;
    checks++; if (tl_a !== 16'h0001 || th_a !== 16'h0001) begin errors++;
      $display("FAIL m3_t1_run got tl %h th %h exp 0001 0001", tl_a, th_a); end
    checks++; if (tf_a !== 2'b00) begin errors++;
      $display("FAIL m3_t1_noflag got %b exp 00", tf_a); end
  endtask

  task automatic test_collision();
    do_reset();
    sfr_wr(8'h89, 8'h01); sfr_wr(8'h8A, 8'hFF); sfr_wr(8'h8C, 8'hFF);
    tr = 2'b01; wr_addr = 8'h8A; data_in = 8'h10; wr = 1'b1;
    cyc(1);
    wr = 1'b0; tr = 2'b00;
    checks++; if (tl_a[7:0] !== 8'h10 || th_a[7:0] !== 8'hFF || tf_a[0] !== 1'b0) begin errors++;
      $display("FAIL wr_wins got %h/%h tf %b exp 10/FF tf 0", tl_a[7:0], th_a[7:0], tf_a[0]); end
    tr = 2'b01; cyc(1); tr = 2'b00;
    checks++; if (tl_a[7:0] !== 8'h11) begin errors++;
      $display("FAIL after_wr got %h exp 11", tl_a[7:0]); end
    sfr_wr(8'h8A, 8'hFF);
    tr = 2'b01; cyc(1); tr = 2'b00;
    checks++; if (tf_a[0] !== 1'b1) begin errors++;
      $display("FAIL pre_ack_set got %b exp 1", tf_a[0]); end
    sfr_wr(8'h8A, 8'hFF); sfr_wr(8'h8C, 8'hFF);
    tr = 2'b01; int_ack = 2'b01; cyc(1); tr = 2'b00; int_ack = 2'b00;
    checks++; if (tf_a[0] !== 1'b1 || tl_a[7:0] !== 8'h00) begin errors++;
      $display("FAIL set_beats_ack got tf %b tl %h exp 1 00", tf_a[0], tl_a[7:0]); end
    int_ack = 2'b01; cyc(1); int_ack = 2'b00;
    checks++; if (tf_a[0] !== 1'b0) begin errors++;
      $display("FAIL ack_clear got %b exp 0", tf_a[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sfr_wr(8'h89, 8'h01); sfr_wr(8'h8A, 8'hFF); sfr_wr(8'h8C, 8'hFF);
    tr = 2'b01;
    cyc(3);
    checks++; if (tl_a[7:0] !== 8'h02 || tf_a[0] !== 1'b1) begin errors++;
      $display("FAIL mid_count got %h tf %b exp 02 tf 1", tl_a[7:0], tf_a[0]); end
    reset = 1'b1;
    cyc(1);
    checks++; if ({tmod_a, tl_a, th_a, tf_a} !== 42'd0) begin errors++;
      $display("FAIL mid_reset_a got %h exp 0", {tmod_a, tl_a, th_a, tf_a}); end
    checks++; if ({tmod_b, tl_b, th_b, tf_b} !== 42'd0) begin errors++;
      $display("FAIL mid_reset_b got %h exp 0", {tmod_b, tl_b, th_b, tf_b}); end
    reset = 1'b0; tr = 2'b00;
  endtask

  initial begin
    reset = 1'b1; wr_addr = 8'h00; data_in = 8'h00; wr = 1'b0; wr_bit = 1'b0;
    tr = 2'b00; int_n = 2'b11; t_pin = 2'b11; int_ack = 2'b00;
    @(negedge clock);
    test_reset();
    test_mode1_overflow();
    test_mode2_reload();
    test_gate();
`ifdef TIMER_EXT_COUNT_EN
    test_ext_count();
`else
    test_ct_ignored();
`endif
    test_mode3();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
